// File: rtl/axis_client_arbiter_if.sv
// Bundle of the client request streams and the shared NoC AXI-Stream master
// port. The master modport is the arbiter's view, the slave modport is the
// view of whatever drives the clients and consumes the NoC stream.
interface axis_client_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATAW   = 128,
    parameter int DESTW   = 4,
    parameter int USERW   = 66,
    parameter int IDW     = 32,
    parameter int STRBW   = 8
);
    logic [NUM_REQ-1:0]       req_tvalid;
    logic [NUM_REQ-1:0]       req_tready;
    logic [NUM_REQ-1:0]       req_tlast;
    logic [NUM_REQ*DATAW-1:0] req_tdata;
    logic [NUM_REQ*DESTW-1:0] req_tdest;
    logic [NUM_REQ*USERW-1:0] req_tuser;

    logic                     m_tvalid;
    logic                     m_tready;
    logic                     m_tlast;
    logic [DATAW-1:0]         m_tdata;
    logic [DESTW-1:0]         m_tdest;
    logic [USERW-1:0]         m_tuser;
    logic [IDW-1:0]           m_tid;
    logic [STRBW-1:0]         m_tstrb;
    logic [STRBW-1:0]         m_tkeep;

    modport master (
        input  req_tvalid, req_tlast, req_tdata, req_tdest, req_tuser, m_tready,
        output req_tready, m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser,
               m_tid, m_tstrb, m_tkeep
    );

    modport slave (
        output req_tvalid, req_tlast, req_tdata, req_tdest, req_tuser, m_tready,
        input  req_tready, m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser,
               m_tid, m_tstrb, m_tkeep
    );
endinterface

// File: rtl/axis_client_arbiter.sv
// Packet-granular round-robin arbiter: several client AXI-Stream sources share
// one NoC master port. A grant is taken in a single IDLE cycle and held until
// the tlast handshake, so packets from different clients never interleave.
module axis_client_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATAW     = 128,
    parameter int DESTW     = 4,
    parameter int USERW     = 66,
    parameter int IDW       = 32,
    parameter int STRBW     = 8,
    parameter int MAX_BEATS = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_client_arbiter_if.master      axis,
    output logic [$clog2(NUM_REQ)-1:0] o_grantId,
    output logic                       o_busy,
    output logic                       o_pktErr
);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [GW-1:0]      r_rrPtr;
    logic [GW-1:0]      r_grantId;
    logic [GW-1:0]      w_pick;
    logic [GW-1:0]      w_nextPtr;
    logic               w_anyReq;
    logic [IDW-1:0]     r_tid;
    logic [BCW-1:0]     r_beatCnt;
    logic               r_pktErr;
    logic               w_mTvalid;
    logic               w_mTlast;
    logic [NUM_REQ-1:0] w_reqTready;
    logic               w_beat;

    assign w_anyReq  = |axis.req_tvalid;
    assign w_beat    = w_mTvalid & axis.m_tready;
    assign w_nextPtr = (r_grantId == GW'(NUM_REQ - 1)) ? '0 : r_grantId + 1'b1;

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        int   idx;
        logic found;
        w_pick = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rrPtr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && axis.req_tvalid[GW'(idx)]) begin
                found  = 1'b1;
                w_pick = GW'(idx);
            end
        end
    end

    // Next-state logic and routing of the granted client onto the master port
    always_comb begin
        w_nextState = r_state;
        w_mTvalid   = 1'b0;
        w_mTlast    = 1'b0;
        w_reqTready = '0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = BURST;
                end
            end
            BURST: begin
                w_mTvalid              = axis.req_tvalid[r_grantId];
                w_mTlast               = axis.req_tlast[r_grantId];
                w_reqTready[r_grantId] = axis.m_tready;
                if (w_mTvalid && axis.m_tready && w_mTlast) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (rst) begin
            w_mTvalid   = 1'b0;
            w_reqTready = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant capture, beat counting, overlong-packet flag, pointer and packet id
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr   <= '0;
            r_grantId <= '0;
            r_tid     <= '0;
            r_beatCnt <= '0;
            r_pktErr  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_anyReq) begin
                r_grantId <= w_pick;
                r_beatCnt <= '0;
            end
        end else if (w_beat) begin
            if (r_beatCnt != BCW'(MAX_BEATS)) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end
            if (!w_mTlast && (r_beatCnt >= BCW'(MAX_BEATS - 1))) begin
                r_pktErr <= 1'b1;
            end
            if (w_mTlast) begin
                r_rrPtr <= w_nextPtr;
                r_tid   <= r_tid + 1'b1;
            end
        end
    end

    assign axis.req_tready = w_reqTready;
    assign axis.m_tvalid   = w_mTvalid;
    assign axis.m_tlast    = w_mTlast;
    assign axis.m_tdata    = axis.req_tdata[int'(r_grantId) * DATAW +: DATAW];
    assign axis.m_tdest    = axis.req_tdest[int'(r_grantId) * DESTW +: DESTW];
    assign axis.m_tuser    = axis.req_tuser[int'(r_grantId) * USERW +: USERW];
    assign axis.m_tid      = r_tid;
    assign axis.m_tstrb    = '0;
    assign axis.m_tkeep    = '0;

    assign o_grantId = r_grantId;
    assign o_busy    = (r_state == BURST);
    assign o_pktErr  = r_pktErr;
endmodule

// File: tb/tb_axis_client_arbiter.sv
// Scoreboard bench for axis_client_arbiter: client queues feed the request
// ports, expected master-side beats are queued in the order the arbiter is
// supposed to serve them and compared beat by beat on the NoC side.
module tb_axis_client_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATAW     = 128;
    localparam int DESTW     = 4;
    localparam int USERW     = 66;
    localparam int IDW       = 32;
    localparam int STRBW     = 8;
    localparam int MAX_BEATS = 4;
    localparam int GW        = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_client_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DATAW(DATAW), .DESTW(DESTW),
        .USERW(USERW), .IDW(IDW), .STRBW(STRBW)
    ) intf ();

    logic [GW-1:0] grantId;
    logic          busy;
    logic          pktErr;

    axis_client_arbiter #(
        .NUM_REQ(NUM_REQ), .DATAW(DATAW), .DESTW(DESTW), .USERW(USERW),
        .IDW(IDW), .STRBW(STRBW), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axis      (intf.master),
        .o_grantId (grantId),
        .o_busy    (busy),
        .o_pktErr  (pktErr)
    );

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             last;
        logic [7:0]       gap;
    } beat_t;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             last;
        logic [GW-1:0]    grant;
        logic [IDW-1:0]   tid;
        logic [DESTW-1:0] dest;
        logic [USERW-1:0] user;
    } exp_t;

    beat_t          clientQ[NUM_REQ][$];
    exp_t           sbQ[$];
    logic           readyQ[$];
    int             beatCycle[$];
    int             testsRun    = 0;
    int             testsFailed = 0;
    int             cycle       = 0;
    int             pktCnt      = 0;
    logic [IDW-1:0] expTid      = '0;
    logic           stallValid;
    logic [DATAW-1:0] stallData;
    logic           prevLast;

    function automatic logic [USERW-1:0] userOf(input int req, input logic [DATAW-1:0] d);
        return {2'b10, 32'(req), d[31:0]};
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [DATAW-1:0] obs,
                               input logic [DATAW-1:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one packet on a client and its expected beats on the scoreboard
    task automatic applyStimulus(input int req, input int nBeats,
                                 input int gapBeat, input int gapLen);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < nBeats; k++) begin
            b.data = {$urandom(), $urandom(), $urandom(), 8'(req), 8'(pktCnt), 16'(k)};
            b.last = (k == nBeats - 1);
            b.gap  = (k == gapBeat) ? 8'(gapLen) : 8'd0;
            clientQ[req].push_back(b);
            e.data  = b.data;
            e.last  = b.last;
            e.grant = GW'(req);
            e.tid   = expTid;
            e.dest  = DESTW'(req);
            e.user  = userOf(req, b.data);
            sbQ.push_back(e);
        end
        expTid++;
        pktCnt++;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        int pending;
        n       = 0;
        pending = 1;
        while (pending != 0 && n < budget) begin
            nextCycle();
            n++;
            pending = sbQ.size();
            for (int i = 0; i < NUM_REQ; i++) pending += clientQ[i].size();
        end
        checkOutput("drain", pending, 0);
    endtask

    // Client drivers and NoC-side monitor share one loop so that handshakes
    // sampled at the falling edge are retired right after the rising edge
    initial begin
        logic [NUM_REQ-1:0] hs;
        logic [NUM_REQ-1:0] oneHot;
        beat_t b;
        exp_t  e;
        intf.req_tvalid = '0;
        intf.req_tlast  = '0;
        intf.req_tdata  = '0;
        intf.req_tdest  = '0;
        intf.req_tuser  = '0;
        intf.m_tready   = 1'b1;
        stallValid      = 1'b0;
        stallData       = '0;
        prevLast        = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            hs = intf.req_tvalid & intf.req_tready;
            if (prevLast) checkOutput("gap", intf.m_tvalid, 0);
            prevLast = 1'b0;
            if (intf.m_tvalid && intf.m_tready) begin
                beatCycle.push_back(cycle);
                if (stallValid) checkOutput("stallData", intf.m_tdata, stallData);
                stallValid = 1'b0;
                if (sbQ.size() == 0) begin
                    checkOutput("extraBeat", intf.m_tvalid, 0);
                end else begin
                    e      = sbQ.pop_front();
                    oneHot = '0;
                    oneHot[e.grant] = 1'b1;
                    checkOutput("data", intf.m_tdata, e.data);
                    checkOutput("last", intf.m_tlast, e.last);
                    checkOutput("grant", grantId, e.grant);
                    checkOutput("tid", intf.m_tid, e.tid);
                    checkOutput("dest", intf.m_tdest, e.dest);
                    checkOutput("user", intf.m_tuser, e.user);
                    checkOutput("reqReady", intf.req_tready, oneHot);
                end
                prevLast = intf.m_tlast;
            end else if (intf.m_tvalid) begin
                if (stallValid) checkOutput("stallData", intf.m_tdata, stallData);
                stallValid = 1'b1;
                stallData  = intf.m_tdata;
                checkOutput("stallReady", intf.req_tready, 0);
            end
            if (rst) begin
                stallValid = 1'b0;
                prevLast   = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && clientQ[i].size() != 0) void'(clientQ[i].pop_front());
                if (clientQ[i].size() != 0) begin
                    b = clientQ[i].pop_front();
                    if (b.gap != 8'd0) begin
                        intf.req_tvalid[i] = 1'b0;
                        b.gap = b.gap - 8'd1;
                    end else begin
                        intf.req_tvalid[i]                 = 1'b1;
                        intf.req_tlast[i]                  = b.last;
                        intf.req_tdata[i*DATAW +: DATAW]   = b.data;
                        intf.req_tdest[i*DESTW +: DESTW]   = DESTW'(i);
                        intf.req_tuser[i*USERW +: USERW]   = userOf(i, b.data);
                    end
                    clientQ[i].push_front(b);
                end else begin
                    intf.req_tvalid[i] = 1'b0;
                    intf.req_tlast[i]  = 1'b0;
                end
            end
            intf.m_tready = (readyQ.size() != 0) ? readyQ.pop_front() : 1'b1;
        end
    end

    // Time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence
    initial begin
        int n;
        int diff;
        bit checkNext;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        nextCycle();
        checkOutput("rstTvalid", intf.m_tvalid, 0);
        checkOutput("rstTready", intf.req_tready, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstGrant", grantId, 0);
        checkOutput("rstTid", intf.m_tid, 0);
        checkOutput("rstErr", pktErr, 0);
        checkOutput("tstrb", intf.m_tstrb, 0);
        checkOutput("tkeep", intf.m_tkeep, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nextCycle();

        // Single requester, 3 beats, one-cycle grant latency
        applyStimulus(1, 3, -1, 0);
        nextCycle();
        checkOutput("lat0", intf.m_tvalid, 0);
        nextCycle();
        checkOutput("lat1", intf.m_tvalid, 1);
        checkOutput("t1Grant", grantId, 1);
        checkOutput("t1Busy", busy, 1);
        waitDrain(50);
        checkOutput("t1Tid", intf.m_tid, 1);
        checkOutput("t1Idle", busy, 0);

        // All four requesters pending out of reset: order 0,1,2,3,0
        rst    = 1'b1;
        expTid = '0;
        applyStimulus(0, 2, -1, 0);
        applyStimulus(1, 2, -1, 0);
        applyStimulus(2, 2, -1, 0);
        applyStimulus(3, 2, -1, 0);
        applyStimulus(0, 2, -1, 0);
        beatCycle.delete();
        repeat (2) nextCycle();
        checkOutput("t2RstTvalid", intf.m_tvalid, 0);
        checkOutput("t2RstTready", intf.req_tready, 0);
        checkOutput("t2RstTid", intf.m_tid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        waitDrain(100);
        checkOutput("t2Beats", beatCycle.size(), 10);
        for (int k = 1; k < beatCycle.size(); k++) begin
            diff = beatCycle[k] - beatCycle[k-1];
            checkOutput("t2Spacing", diff, (k % 2 == 1) ? 1 : 2);
        end

        // Back-pressure toggling during a req2 packet
        readyQ = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        applyStimulus(2, 3, -1, 0);
        waitDrain(60);

        // req0 drops valid for 5 cycles mid-packet while req3 waits
        applyStimulus(0, 3, 1, 5);
        applyStimulus(3, 2, 0, 2);
        repeat (5) nextCycle();
        checkOutput("t4Hold", grantId, 0);
        checkOutput("t4Busy", busy, 1);
        checkOutput("t4Tvalid", intf.m_tvalid, 0);
        checkOutput("t4Ready3", intf.req_tready[3], 0);
        waitDrain(80);
        checkOutput("t4NoErr", pktErr, 0);

        // Overlong packet: 6 beats with MAX_BEATS=4
        applyStimulus(1, 6, -1, 0);
        n         = 0;
        checkNext = 1'b0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            nextCycle();
            if (checkNext) begin
                checkOutput("errSet", pktErr, 1);
                checkNext = 1'b0;
            end
            if (intf.m_tvalid && intf.m_tready) begin
                n++;
                if (n == 4) begin
                    checkOutput("errPre", pktErr, 0);
                    checkNext = 1'b1;
                end
            end
        end
        checkOutput("t5Beats", n, 6);
        waitDrain(20);
        checkOutput("errSticky", pktErr, 1);

        // Reset on beat 2 of a 4-beat packet from req3
        applyStimulus(3, 4, -1, 0);
        n = 0;
        for (int c = 0; c < 40 && n < 1; c++) begin
            nextCycle();
            if (intf.m_tvalid && intf.m_tready) n++;
        end
        checkOutput("t6Start", n, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        nextCycle();
        checkOutput("t6Tvalid", intf.m_tvalid, 0);
        checkOutput("t6Tready", intf.req_tready, 0);
        clientQ[3].delete();
        sbQ.delete();
        expTid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        nextCycle();
        checkOutput("t6Busy", busy, 0);
        checkOutput("t6Tid", intf.m_tid, 0);
        checkOutput("t6Err", pktErr, 0);
        checkOutput("t6Grant", grantId, 0);
        checkOutput("t6Idle", intf.m_tvalid, 0);
        applyStimulus(1, 2, -1, 0);
        applyStimulus(3, 2, -1, 0);
        waitDrain(60);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
